// File: rtl/ntt_sched_pkg.sv
// Shared types and sizing for the NTT job scheduler.
// Holds the FSM state encoding plus the default requester count and job length.
package ntt_sched_pkg;

    localparam int KYBER_N = 256;
    localparam int NUM_REQ = 3;
    localparam int ID_W    = 2;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_WAIT  = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: combinational winner; the search starts one past the last grant.
// Zero latency; the pointer only moves when the caller takes the grant (i_update).
module rr_arbiter
    import ntt_sched_pkg::*;
#(
    parameter int N = 3
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic [N-1:0]    i_req,
    input  logic            i_update,
    output logic            o_any,
    output logic [ID_W-1:0] o_id,
    output logic [N-1:0]    o_gnt
);

    localparam logic [ID_W:0] N_W = (ID_W + 1)'(N);

    logic [ID_W-1:0] ptr_q;
    logic [ID_W:0]   sum;

    always_comb begin
        o_any = 1'b0;
        o_id  = '0;
        sum   = '0;
        for (int i = 0; i < N; i++) begin
            sum = {1'b0, ptr_q} + (ID_W + 1)'(i);
            if (sum >= N_W) begin
                sum = sum - N_W;
            end
            if (!o_any && i_req[sum[ID_W-1:0]]) begin
                o_any = 1'b1;
                o_id  = sum[ID_W-1:0];
            end
        end
        o_gnt = o_any ? (N'(1) << o_id) : '0;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            ptr_q <= '0;
        end else if (i_update && o_any) begin
            ptr_q <= ({1'b0, o_id} == N_W - 1'b1) ? '0 : o_id + 1'b1;
        end
    end

endmodule

// File: rtl/ntt_sched.sv
// Shares one NTT core between NUM_REQ requesters: arbitrate, stream a job in, forward the result.
// Load/result paths are zero-latency pass-throughs; input stalls on i_in_valid gaps, results have no backpressure.
module ntt_sched #(
    parameter int NUM_REQ = ntt_sched_pkg::NUM_REQ,
    parameter int KYBER_N = ntt_sched_pkg::KYBER_N,
    parameter int TIMEOUT = 4095
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic [NUM_REQ-1:0]       i_req,
    input  logic [NUM_REQ-1:0]       i_req_intt,
    input  logic [NUM_REQ-1:0]       i_in_valid,
    input  logic [NUM_REQ-1:0][15:0] i_in_data,
    output logic [NUM_REQ-1:0]       o_in_ack,
    output logic [NUM_REQ-1:0]       o_grant,
    output logic                     o_core_ready,
    output logic                     o_core_intt,
    output logic [15:0]              o_core_data,
    input  logic                     i_core_valid,
    input  logic [15:0]              i_core_data,
    output logic                     o_core_rst,
    output logic                     o_out_valid,
    output logic [15:0]              o_out_data,
    output logic [1:0]               o_out_id,
    output logic                     o_done,
    output logic                     o_err
);

    import ntt_sched_pkg::*;

    localparam int            TW   = $clog2(TIMEOUT + 1);
    localparam logic [8:0]    LAST = 9'(KYBER_N - 1);
    localparam logic [TW-1:0] TLIM = TW'(TIMEOUT - 1);

    state_t              state_q, state_d;
    logic [NUM_REQ-1:0]  grant_q;
    logic [ID_W-1:0]     gid_q;
    logic                intt_q;
    logic [8:0]          wcnt_q, wcnt_d;
    logic [TW-1:0]       tcnt_q, tcnt_d;
    logic                do_grant, job_end, err_c;

    logic                arb_any;
    logic [ID_W-1:0]     arb_id;
    logic [NUM_REQ-1:0]  arb_gnt;

    rr_arbiter #(.N(NUM_REQ)) u_arb (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_req    (i_req),
        .i_update (do_grant),
        .o_any    (arb_any),
        .o_id     (arb_id),
        .o_gnt    (arb_gnt)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= S_IDLE;
            grant_q <= '0;
            gid_q   <= '0;
            intt_q  <= 1'b0;
            wcnt_q  <= '0;
            tcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            tcnt_q  <= tcnt_d;
            if (do_grant) begin
                grant_q <= arb_gnt;
                gid_q   <= arb_id;
                intt_q  <= i_req_intt[arb_id];
            end else if (job_end) begin
                grant_q <= '0;
                gid_q   <= '0;
                intt_q  <= 1'b0;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        wcnt_d       = wcnt_q;
        tcnt_d       = tcnt_q;
        do_grant     = 1'b0;
        job_end      = 1'b0;
        err_c        = 1'b0;
        o_in_ack     = '0;
        o_core_ready = 1'b0;
        o_core_data  = '0;
        o_core_rst   = 1'b0;
        o_out_valid  = 1'b0;
        o_out_data   = '0;
        o_out_id     = '0;
        o_done       = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                // A stray core word here is flagged but never forwarded.
                err_c = i_core_valid;
                if (arb_any) begin
                    do_grant = 1'b1;
                    state_d  = S_LOAD;
                end
            end
            S_LOAD: begin
                err_c           = i_core_valid;
                o_core_ready    = i_in_valid[gid_q];
                o_core_data     = i_in_data[gid_q];
                o_in_ack[gid_q] = i_in_valid[gid_q];
                if (i_in_valid[gid_q]) begin
                    if (wcnt_q == LAST) begin
                        wcnt_d  = '0;
                        tcnt_d  = '0;
                        state_d = S_WAIT;
                    end else begin
                        wcnt_d = wcnt_q + 9'd1;
                    end
                end
            end
            S_WAIT: begin
                o_out_valid = i_core_valid;
                o_out_data  = i_core_data;
                o_out_id    = gid_q;
                if (i_core_valid) begin
                    wcnt_d  = 9'd1;
                    state_d = S_DRAIN;
                end else if (tcnt_q == TLIM) begin
                    err_c      = 1'b1;
                    o_core_rst = 1'b1;
                    job_end    = 1'b1;
                    tcnt_d     = '0;
                    state_d    = S_IDLE;
                end else begin
                    tcnt_d = tcnt_q + 1'b1;
                end
            end
            S_DRAIN: begin
                o_out_valid = i_core_valid;
                o_out_data  = i_core_data;
                o_out_id    = gid_q;
                if (i_core_valid) begin
                    if (wcnt_q == LAST) begin
                        o_done  = 1'b1;
                        job_end = 1'b1;
                        wcnt_d  = '0;
                        state_d = S_IDLE;
                    end else begin
                        wcnt_d = wcnt_q + 9'd1;
                    end
                end else begin
                    // Core stalled mid-result: the job is lost, reset the core.
                    err_c      = 1'b1;
                    o_core_rst = 1'b1;
                    job_end    = 1'b1;
                    wcnt_d     = '0;
                    state_d    = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign o_grant     = grant_q;
    assign o_core_intt = intt_q;
    assign o_err       = err_c & ~i_rst;

endmodule

// File: tb/tb_ntt_sched.sv
// Directed bench for ntt_sched: arbitration order, load/drain streaming, timeout, drop and reset recovery.
module tb_ntt_sched;

    localparam int NR = 3;
    localparam int KN = 256;
    localparam int TO = 4095;

    logic                clk = 1'b0;
    logic                i_rst;
    logic [NR-1:0]       i_req, i_req_intt, i_in_valid;
    logic [NR-1:0][15:0] i_in_data;
    logic [NR-1:0]       o_in_ack, o_grant;
    logic                o_core_ready, o_core_intt;
    logic [15:0]         o_core_data;
    logic                i_core_valid;
    logic [15:0]         i_core_data;
    logic                o_core_rst, o_out_valid;
    logic [15:0]         o_out_data;
    logic [1:0]          o_out_id;
    logic                o_done, o_err;
    logic [45:0]         outs;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    ntt_sched #(.NUM_REQ(NR), .KYBER_N(KN), .TIMEOUT(TO)) dut (
        .i_clk        (clk),
        .i_rst        (i_rst),
        .i_req        (i_req),
        .i_req_intt   (i_req_intt),
        .i_in_valid   (i_in_valid),
        .i_in_data    (i_in_data),
        .o_in_ack     (o_in_ack),
        .o_grant      (o_grant),
        .o_core_ready (o_core_ready),
        .o_core_intt  (o_core_intt),
        .o_core_data  (o_core_data),
        .i_core_valid (i_core_valid),
        .i_core_data  (i_core_data),
        .o_core_rst   (o_core_rst),
        .o_out_valid  (o_out_valid),
        .o_out_data   (o_out_data),
        .o_out_id     (o_out_id),
        .o_done       (o_done),
        .o_err        (o_err)
    );

    assign outs = {o_in_ack, o_grant, o_core_ready, o_core_intt, o_core_data, o_core_rst,
                   o_out_valid, o_out_data, o_out_id, o_done, o_err};

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] pat(input int rid, input int k);
        return 16'(rid * 4096 + k * 3 + 1);
    endfunction

    // Waits for the grant of requester rid, then streams nstop words into it.
    task automatic load_job(input int rid, input bit gappy, input int nstop,
                            input logic [NR-1:0] keep, input bit intt);
        int cyc, acks, bad;
        logic [NR-1:0] oh, exp_ack;
        oh  = NR'(1) << rid;
        cyc = 0;
        do begin
            @(negedge clk);
            #1;
            cyc++;
        end while (o_grant == '0 && cyc < 8);
        check($sformatf("grant_r%0d", rid), 64'(o_grant), 64'(oh));
        i_req = i_req & keep;
        acks = 0;
        cyc  = 0;
        bad  = 0;
        while (acks < nstop && cyc < 1200) begin
            i_in_valid = (gappy && cyc[0]) ? ~oh : '1;
            for (int r = 0; r < NR; r++) i_in_data[r] = pat(r + 4, cyc);
            i_in_data[rid] = 16'(acks);
            exp_ack = i_in_valid[rid] ? oh : '0;
            #1;
            if (o_in_ack !== exp_ack || o_core_ready !== exp_ack[rid] || o_core_intt !== intt) bad++;
            if (o_in_ack[rid] === 1'b1) begin
                if (o_core_data !== 16'(acks)) bad++;
                acks++;
            end
            @(negedge clk);
            cyc++;
        end
        i_in_valid = '0;
        check($sformatf("load_bad_r%0d", rid), 64'(bad), 64'd0);
        check($sformatf("load_acks_r%0d", rid), 64'(acks), 64'(nstop));
        if (nstop == KN) check($sformatf("load_cycles_r%0d", rid), 64'(cyc), gappy ? 64'(2 * KN - 1) : 64'(KN));
    endtask

    // Core model: silent for delay cycles, then returns nwords result words.
    task automatic core_return(input int rid, input int nwords, input int delay, input bit intt);
        int bad, nd, dpos;
        bad  = 0;
        nd   = 0;
        dpos = -1;
        for (int k = 0; k < delay; k++) begin
            i_core_valid = 1'b0;
            #1;
            if (o_err !== 1'b0 || o_out_valid !== 1'b0 || o_core_intt !== intt) bad++;
            @(negedge clk);
        end
        for (int k = 0; k < nwords; k++) begin
            i_core_valid = 1'b1;
            i_core_data  = pat(rid, k);
            #1;
            if (o_out_valid !== 1'b1 || o_out_data !== pat(rid, k) || o_out_id !== 2'(rid) ||
                o_core_intt !== intt || o_err !== 1'b0 || o_core_rst !== 1'b0) bad++;
            if (o_done === 1'b1) begin
                nd++;
                dpos = k;
            end
            @(negedge clk);
        end
        i_core_valid = 1'b0;
        i_core_data  = '0;
        check($sformatf("drain_bad_r%0d", rid), 64'(bad), 64'd0);
        if (nwords == KN) begin
            check("done_count", 64'(nd), 64'd1);
            check("done_pos", 64'(dpos), 64'(KN - 1));
            #1;
            check("grant_clear", 64'(o_grant), 64'd0);
            check("intt_clear", 64'(o_core_intt), 64'd0);
        end else begin
            #1;
            check("drop_err", 64'(o_err), 64'd1);
            check("drop_core_rst", 64'(o_core_rst), 64'd1);
            check("drop_no_done", 64'(nd) + 64'(o_done), 64'd0);
            @(negedge clk);
            #1;
            check("drop_idle", 64'(o_grant), 64'd0);
        end
        @(negedge clk);
    endtask

    initial begin
        int k, errk;
        logic rst_at;
        i_rst        = 1'b1;
        i_req        = '0;
        i_req_intt   = '0;
        i_in_valid   = '0;
        i_in_data    = '0;
        i_core_valid = 1'b0;
        i_core_data  = '0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_outs", 64'(outs), 64'd0);
        i_rst = 1'b0;
        @(negedge clk);
        #1;
        check("idle_outs", 64'(outs), 64'd0);
        @(negedge clk);

        // All three requesting: order 0,1,2 then 0 again.
        i_req = '1;
        load_job(0, 1'b0, KN, 3'b111, 1'b0); core_return(0, KN, 3, 1'b0);
        load_job(1, 1'b0, KN, 3'b111, 1'b0); core_return(1, KN, 1, 1'b0);
        load_job(2, 1'b0, KN, 3'b111, 1'b0); core_return(2, KN, 0, 1'b0);
        load_job(0, 1'b0, KN, 3'b000, 1'b0); core_return(0, KN, 2, 1'b0);

        // Single requester 0, contiguous load.
        i_req = 3'b001;
        load_job(0, 1'b0, KN, 3'b000, 1'b0); core_return(0, KN, 5, 1'b0);

        // Core word while idle: error, nothing forwarded, still idle.
        i_core_valid = 1'b1;
        i_core_data  = 16'hBEEF;
        #1;
        check("idle_err", 64'(o_err), 64'd1);
        check("idle_no_fwd", 64'(o_out_valid), 64'd0);
        check("idle_no_data", 64'(o_out_data), 64'd0);
        @(negedge clk);
        i_core_valid = 1'b0;
        #1;
        check("idle_err_clear", 64'(o_err), 64'd0);
        check("idle_stay", 64'(o_grant), 64'd0);
        @(negedge clk);

        // Requester 1, inverse NTT, valid toggling every other cycle.
        i_req      = 3'b010;
        i_req_intt = 3'b010;
        load_job(1, 1'b1, KN, 3'b000, 1'b1); core_return(1, KN, 4, 1'b1);
        i_req_intt = '0;

        // Core drops valid after 100 result words.
        i_req = 3'b001;
        load_job(0, 1'b0, KN, 3'b000, 1'b0); core_return(0, 100, 2, 1'b0);

        // Silent core: timeout, then pending requester 0 gets the core.
        i_req = 3'b101;
        load_job(2, 1'b0, KN, 3'b001, 1'b0);
        k      = 0;
        errk   = 0;
        rst_at = 1'b0;
        while (errk == 0 && k < 5000) begin
            i_core_valid = 1'b0;
            #1;
            k++;
            if (o_err === 1'b1) begin
                errk   = k;
                rst_at = o_core_rst;
            end
            @(negedge clk);
        end
        check("timeout_cycle", 64'(errk), 64'(TO));
        check("timeout_core_rst", 64'(rst_at), 64'd1);
        load_job(0, 1'b0, 50, 3'b000, 1'b0);

        // Reset in the middle of loading word 50.
        i_rst        = 1'b1;
        i_in_valid   = '1;
        i_core_valid = 1'b1;
        i_core_data  = 16'h1234;
        #1;
        check("rst_mid_outs", 64'(outs), 64'd0);
        @(negedge clk);
        #1;
        check("rst_hold_outs", 64'(outs), 64'd0);
        i_in_valid   = '0;
        i_core_valid = 1'b0;
        i_rst        = 1'b0;
        #1;
        check("post_rst_outs", 64'(outs), 64'd0);
        @(negedge clk);
        i_req = '1;
        @(negedge clk);
        #1;
        check("rr_after_rst", 64'(o_grant), 64'd1);
        i_rst = 1'b1;
        i_req = '0;
        #1;
        check("rst2_grant", 64'(o_grant), 64'd0);
        @(negedge clk);
        i_rst = 1'b0;
        @(negedge clk);
        i_req = 3'b100;
        load_job(2, 1'b0, KN, 3'b000, 1'b0); core_return(2, KN, 3, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/ntt_sched.md
NTT_SCHED -- requirements
Module: ntt_sched

Interface
REQ-001 SHALL have parameter NUM_REQ, default 3, meaning number of requesters sharing one NTT core.
REQ-002 SHALL have parameter KYBER_N, default 256, meaning coefficients per job in each direction.
REQ-003 SHALL have parameter TIMEOUT, default 4095, meaning max cycles in S_WAIT before abort.
REQ-004 SHALL have port i_clk  input  1  clock.
REQ-005 SHALL have port i_rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port i_req  input  NUM_REQ  per-requester job request, level.
REQ-007 SHALL have port i_req_intt  input  NUM_REQ  per-requester inverse-NTT flag, sampled at grant.
REQ-008 SHALL have port i_in_valid  input  NUM_REQ  per-requester input coefficient valid.
REQ-009 SHALL have port i_in_data  input  NUM_REQ x 16  per-requester input coefficient.
REQ-010 SHALL have port o_in_ack  output  NUM_REQ  coefficient consumed this cycle, one-hot or zero.
REQ-011 SHALL have port o_grant  output  NUM_REQ  one-hot owner of the core, zero when idle.
REQ-012 SHALL have port o_core_ready  output  1  drives core i_ready, one load word per high cycle.
REQ-013 SHALL have port o_core_intt  output  1  drives core i_intt.
REQ-014 SHALL have port o_core_data  output  16  drives core i_data.
REQ-015 SHALL have port i_core_valid  input  1  core o_valid.
REQ-016 SHALL have port i_core_data  input  16  core o_data.
REQ-017 SHALL have port o_core_rst  output  1  one-cycle core reset pulse on abort.
REQ-018 SHALL have port o_out_valid  output  1  result coefficient valid, no backpressure.
REQ-019 SHALL have port o_out_data  output  16  result coefficient.
REQ-020 SHALL have port o_out_id  output  2  index of requester owning o_out_data.
REQ-021 SHALL have port o_done  output  1  one-cycle pulse with last result coefficient.
REQ-022 SHALL have port o_err  output  1  one-cycle pulse on timeout or protocol error.

Function
REQ-023 SHALL implement states S_IDLE, S_LOAD, S_WAIT, S_DRAIN.
REQ-024 S_IDLE: any i_req high -> register round-robin winner into grant, latch i_req_intt[winner], go S_LOAD next cycle; o_grant high from S_LOAD entry.
REQ-025 Round-robin: search starts at index after last granted; after reset search starts at 0.
REQ-026 S_LOAD: o_core_ready = o_in_ack[gid] = i_in_valid[gid], o_core_data = i_in_data[gid], combinational; other acks 0.
REQ-027 S_LOAD: 9-bit word counter increments per ack; on 256th ack go S_WAIT, counter cleared.
REQ-028 Gaps in i_in_valid SHALL stall loading without counter change; i_req deassert after grant SHALL be ignored (job committed).
REQ-029 o_core_intt SHALL hold latched flag from grant until return to S_IDLE.
REQ-030 S_WAIT: cycle counter increments; i_core_valid high -> S_DRAIN with that word forwarded same cycle.
REQ-031 S_WAIT: counter reaching TIMEOUT without i_core_valid -> pulse o_err and o_core_rst, go S_IDLE, grant cleared, pointer advanced.
REQ-032 o_out_valid = i_core_valid, o_out_data = i_core_data, o_out_id = gid in S_WAIT/S_DRAIN, zero-latency.
REQ-033 S_DRAIN: counts valid words; 256th word -> o_done pulse same cycle, S_IDLE next; arbitration for next job in S_IDLE following.
REQ-034 i_core_valid low inside S_DRAIN before 256 words -> o_err pulse, o_core_rst pulse, S_IDLE.
REQ-035 i_core_valid high in S_IDLE or S_LOAD -> o_err pulse, data not forwarded (o_out_valid 0), state unchanged.
REQ-036 All counters 9 bits for load/drain, clog2(TIMEOUT+1) bits for wait; no wrap.

Reset
REQ-037 Reset SHALL force S_IDLE, counters 0, pointer 0, latched intt 0, grant 0.
REQ-038 All outputs SHALL be 0 during and after reset until a grant; reset mid-job abandons it silently (no o_done, no o_err).

Structure
REQ-039 Package ntt_sched_pkg SHALL hold state enum, KYBER_N, NUM_REQ, id width constant.
REQ-040 Sub-module rr_arbiter (NUM_REQ-wide, registered pointer, update on grant) SHALL be instantiated once.

Verification
REQ-041 Single req0, intt=0, 256 contiguous words 0..255, core model returns 256 words -> o_grant=001, 256 acks, o_out_id=0, o_done once at 256th output.
REQ-042 i_req=111 held, three jobs -> grant order 0,1,2, then 0 again; o_out_id matches each drain.
REQ-043 req1 intt=1, i_in_valid toggling every other cycle -> exactly 256 acks over 511 cycles, o_core_intt=1 throughout job.
REQ-044 Core model silent after load -> o_err and o_core_rst pulse at S_WAIT cycle 4095, then next pending req granted.
REQ-045 Core model drops valid after 100 output words -> o_err at word 101 cycle, no o_done, back to S_IDLE.
REQ-046 Assert i_rst during S_LOAD word 50 -> all outputs 0, restart with req2 -> full job completes normally, grant search from index 0.
